// File: rtl/axi_pkg.sv
// axi_pkg
// Shared definitions for the AXI SRAM responder.
//   Burst codes     : FIXED, INCR, WRAP
//   Response codes  : OKAY, SLVERR
//   state_e         : controller states IDLE, WDATA, WRESP, RDATA
package axi_pkg;

   localparam logic [1:0] FIXED  = 2'b00;
   localparam logic [1:0] INCR   = 2'b01;
   localparam logic [1:0] WRAP   = 2'b10;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WDATA = 2'd1,
      WRESP = 2'd2,
      RDATA = 2'd3
   } state_e;

endpackage

// File: rtl/axi_ifc.sv
// axi_ifc
// AXI bus bundle between one requester (modport master) and one
// responder (modport slave).
//   AWIDTH : address width
//   DWIDTH : data width (wstrb is DWIDTH/8 bits)
//   IWIDTH : transaction ID width
//   AXI3   : 1 -> 4-bit len and 2-bit lock, 0 -> 8-bit len and 1-bit lock
interface axi_ifc #(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int IWIDTH = 1,
   parameter int AXI3   = 1
);
   localparam int LW = (AXI3 != 0) ? 4 : 8;
   localparam int KW = (AXI3 != 0) ? 2 : 1;

   logic [IWIDTH-1:0]   awid;
   logic [AWIDTH-1:0]   awaddr;
   logic [LW-1:0]       awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic [KW-1:0]       awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic                awvalid;
   logic                awready;

   logic [IWIDTH-1:0]   wid;
   logic [DWIDTH-1:0]   wdata;
   logic [DWIDTH/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic [IWIDTH-1:0]   bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   logic [IWIDTH-1:0]   arid;
   logic [AWIDTH-1:0]   araddr;
   logic [LW-1:0]       arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic [KW-1:0]       arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic                arvalid;
   logic                arready;

   logic [IWIDTH-1:0]   rid;
   logic [DWIDTH-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      input  awready,
      output wid, wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
      output awready,
      input  wid, wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/sram_bytewrite.sv
// sram_bytewrite
// Single-port word memory, 2^ABITS x 32 bits, with per-byte write enables
// and a registered (1-cycle) read. Contents are never reset.
//   clk   : clock
//   addr  : word index used for both read and write
//   we    : byte write enables, bit i writes wdata[8i+7:8i]
//   wdata : write data
//   rdata : mem[addr] as sampled on the previous clock edge
module sram_bytewrite
   import axi_pkg::*;
#(
   parameter int ABITS = 10
) (
   input  logic             clk,
   input  logic [ABITS-1:0] addr,
   input  logic [3:0]       we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata
);

   logic [31:0] mem [0:(1<<ABITS)-1];
   logic [31:0] rdata_d;
   logic [31:0] rdata_q;

   // Read port looks up the addressed word; the flop below gives the 1-cycle latency.
   always_comb begin
      rdata_d = mem[addr];
   end

   // Byte-masked write plus read register. A read of the word being written
   // returns the old contents.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_sram_slave.sv
// axi_sram_slave
// AXI responder in front of a byte-writable SRAM, one transaction at a time.
//   clk   : clock
//   reset : synchronous active-high reset
//   s     : axi_ifc.slave responder end of the bus
// Optional build macro AXI_SRAM_RANGE_CHECK_EN: addresses with any bit set
// above the memory range are answered with SLVERR, writes are dropped and
// reads return zero. Without it the upper address bits alias.
// Requires AWIDTH > ABITS+2 and a 32-bit data path.
module axi_sram_slave
   import axi_pkg::*;
#(
   parameter int AWIDTH = 32,
   parameter int DWIDTH = 32,
   parameter int IWIDTH = 1,
   parameter int AXI3   = 1,
   parameter int ABITS  = 10
) (
   input logic   clk,
   input logic   reset,
   axi_ifc.slave s
);

   localparam int LW = (AXI3 != 0) ? 4 : 8;

   state_e            state_q, state_d;
   logic [ABITS-1:0]  idx_q, idx_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     cnt_q, cnt_d;
   logic [1:0]        burst_q, burst_d;
   logic [IWIDTH-1:0] id_q, id_d;
   logic              err_q, err_d;
   logic              rvalid_q, rvalid_d;

   logic              aw_err, ar_err;
   logic [ABITS-1:0]  mem_addr;
   logic [3:0]        mem_we;
   logic [31:0]       mem_rdata;
   logic              bvalid, rvalid;
   logic              unused_sig;

   // INCR and WRAP both step linearly and wrap at the top of memory.
   function automatic logic [ABITS-1:0] next_idx(input logic [ABITS-1:0] idx,
                                                  input logic [1:0]       burst);
      return (burst == FIXED) ? idx : idx + ABITS'(1);
   endfunction

`ifdef AXI_SRAM_RANGE_CHECK_EN
   assign aw_err = |s.awaddr[AWIDTH-1:ABITS+2];
   assign ar_err = |s.araddr[AWIDTH-1:ABITS+2];
`else
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
`endif

   // Next-state and datapath control. In RDATA the first cycle (rvalid_q=0)
   // only primes the SRAM; afterwards the SRAM is always addressed with the
   // index of the beat that will be shown next cycle, so a stall re-reads the
   // same word and a handshake fetches the following one.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      len_d    = len_q;
      cnt_d    = cnt_q;
      burst_d  = burst_q;
      id_d     = id_q;
      err_d    = err_q;
      rvalid_d = rvalid_q;
      mem_we   = 4'b0000;
      case (state_q)
         IDLE: begin
            if (s.arvalid) begin
               idx_d   = s.araddr[ABITS+1:2];
               len_d   = s.arlen;
               burst_d = s.arburst;
               id_d    = s.arid;
               err_d   = ar_err;
               cnt_d   = '0;
               state_d = RDATA;
            end else if (s.awvalid) begin
               idx_d   = s.awaddr[ABITS+1:2];
               len_d   = s.awlen;
               burst_d = s.awburst;
               id_d    = s.awid;
               err_d   = aw_err;
               cnt_d   = '0;
               state_d = WDATA;
            end
         end
         WDATA: begin
            if (s.wvalid) begin
               if (!err_q && !reset) begin
                  mem_we = s.wstrb;
               end
               idx_d = next_idx(idx_q, burst_q);
               cnt_d = cnt_q + LW'(1);
               if (cnt_q == len_q) begin
                  state_d = WRESP;
               end
            end
         end
         WRESP: begin
            if (s.bready) begin
               state_d = IDLE;
            end
         end
         RDATA: begin
            if (!rvalid_q) begin
               rvalid_d = 1'b1;
            end else if (s.rready) begin
               if (cnt_q == len_q) begin
                  rvalid_d = 1'b0;
                  state_d  = IDLE;
               end else begin
                  idx_d = next_idx(idx_q, burst_q);
                  cnt_d = cnt_q + LW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      mem_addr = (state_q == WDATA) ? idx_q : idx_d;
   end

   // State and transaction registers; memory is deliberately not touched by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         burst_q  <= '0;
         id_q     <= '0;
         err_q    <= 1'b0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         len_q    <= len_d;
         cnt_q    <= cnt_d;
         burst_q  <= burst_d;
         id_q     <= id_d;
         err_q    <= err_d;
         rvalid_q <= rvalid_d;
      end
   end

   sram_bytewrite #(.ABITS(ABITS)) u_sram (
      .clk   (clk),
      .addr  (mem_addr),
      .we    (mem_we),
      .wdata (s.wdata),
      .rdata (mem_rdata)
   );

   // Outputs are also masked by reset so they read zero for the whole reset
   // cycle, not just after the first edge.
   assign bvalid    = !reset && (state_q == WRESP);
   assign rvalid    = !reset && rvalid_q;
   assign s.arready = !reset && (state_q == IDLE);
   assign s.awready = !reset && (state_q == IDLE) && !s.arvalid;
   assign s.wready  = !reset && (state_q == WDATA);
   assign s.bvalid  = bvalid;
   assign s.bid     = bvalid ? id_q : '0;
   assign s.bresp   = (bvalid && err_q) ? SLVERR : OKAY;
   assign s.rvalid  = rvalid;
   assign s.rid     = rvalid ? id_q : '0;
   assign s.rresp   = (rvalid && err_q) ? SLVERR : OKAY;
   assign s.rlast   = rvalid && (cnt_q == len_q);
   assign s.rdata   = (rvalid && !err_q) ? mem_rdata : 32'h0;

   assign unused_sig = ^{s.awaddr, s.araddr, s.awsize, s.arsize, s.awlock, s.arlock,
                         s.awcache, s.arcache, s.awprot, s.arprot, s.wlast, s.wid};

endmodule
